// File: rtl/rvj1_hazard_ctrl.sv
// Load-use hazard controller for the rvj1 decode stage: pre-decodes the decode-stage
// instruction, tracks outstanding load destinations and stalls the decoder. Bypass: RVJ1_HAZ_BYPASS_EN.
module rvj1_hazard_ctrl #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned RALEN     = 5,
  parameter int unsigned MAX_LOADS = 2,
  localparam int unsigned CW       = $clog2(MAX_LOADS + 1),
  localparam int unsigned NREG     = 2 ** RALEN
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic [XLEN-1:0]  ifu_instr_i,
  input  logic             ifu_valid_i,
  input  logic             lsu_done_i,
  input  logic [RALEN-1:0] lsu_done_rd_i,
  output logic             stall_o,
  output logic [NREG-1:0]  pending_o,
  output logic [CW-1:0]    outstanding_o,
  output logic             err_o
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic {RUN, STALL} state_t;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   held_q;
  logic [NREG-1:0]   pending_q, pending_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              err_q, err_d;

  logic [XLEN-1:0]   chk;
  logic [6:0]        opcode;
  logic [RALEN-1:0]  rd, rs1, rs2;
  logic              use_rs1, use_rs2, writes_rd, is_load;
  logic [NREG-1:0]   done_mask, busy;
  logic              full, hazard, issue, load_issue;
  logic              unused_bits;

  always_comb begin
    chk       = (state_q == STALL) ? held_q : ifu_instr_i;
    opcode    = chk[6:0];
    rd        = chk[7 +: RALEN];
    rs1       = chk[15 +: RALEN];
    rs2       = chk[20 +: RALEN];
    use_rs1   = opcode inside {OPC_JALR, OPC_LOAD, OPC_OPIMM, OPC_BRANCH, OPC_STORE, OPC_OP};
    use_rs2   = opcode inside {OPC_BRANCH, OPC_STORE, OPC_OP};
    writes_rd = opcode inside {OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_LOAD, OPC_OPIMM, OPC_OP};
    is_load   = (opcode == OPC_LOAD);
  end

  assign unused_bits = ^{chk[XLEN-1:25], chk[14:12]};
  assign done_mask   = lsu_done_i ? (NREG'(1) << lsu_done_rd_i) : '0;

`ifdef RVJ1_HAZ_BYPASS_EN
  // A register is released in the very cycle its load writes back, and so is a load slot.
  assign busy = pending_q & ~done_mask;
  assign full = (cnt_q == CW'(MAX_LOADS)) && !lsu_done_i;
`else
  assign busy = pending_q;
  assign full = (cnt_q == CW'(MAX_LOADS));
`endif

  always_comb begin
    hazard = (use_rs1   && (rs1 != '0) && busy[rs1]) ||
             (use_rs2   && (rs2 != '0) && busy[rs2]) ||
             (writes_rd && (rd  != '0) && busy[rd])  ||
             (is_load   && full);
  end

  assign stall_o       = ifu_valid_i && hazard;
  assign issue         = ifu_valid_i && !hazard;
  assign load_issue    = issue && is_load;
  assign pending_o     = pending_q;
  assign outstanding_o = cnt_q;
  assign err_o         = err_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (stall_o)  state_d = STALL;
      STALL:   if (!stall_o) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    pending_d = pending_q & ~done_mask;
    if (load_issue && (rd != '0)) pending_d[rd] = 1'b1;
    pending_d[0] = 1'b0;

    cnt_d = cnt_q;
    err_d = err_q;
    case ({load_issue, lsu_done_i})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   if (cnt_q == '0) err_d = 1'b1;
               else             cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
    if (lsu_done_i && (lsu_done_rd_i != '0) && !pending_q[lsu_done_rd_i]) err_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= RUN;
      held_q    <= '0;
      pending_q <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      if ((state_q == RUN) && stall_o) held_q <= ifu_instr_i;
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_rvj1_hazard_ctrl.sv
// Self-checking bench for rvj1_hazard_ctrl: directed scenarios plus randomized traffic
// against a behavioural scoreboard model.
module tb_rvj1_hazard_ctrl;

`ifdef RVJ1_HAZ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam int MAXL = 2;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] instr;
  logic        valid, done;
  logic [4:0]  drd;
  logic        stall;
  logic [31:0] pend;
  logic [1:0]  outst;
  logic        err;

  int vectors = 0;
  int miscompares = 0;

  bit [31:0]   m_pend;
  int          m_cnt;
  bit          m_err;
  bit          m_stalled;
  logic [31:0] m_held;

  rvj1_hazard_ctrl #(.XLEN(32), .RALEN(5), .MAX_LOADS(MAXL)) dut (
    .clk_i(clk), .rstn_i(rstn), .ifu_instr_i(instr), .ifu_valid_i(valid),
    .lsu_done_i(done), .lsu_done_rd_i(drd), .stall_o(stall), .pending_o(pend),
    .outstanding_o(outst), .err_o(err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mk_load(input int rd, input int rs1);
    mk_load = {12'd0, 5'(rs1), 3'b010, 5'(rd), 7'b0000011};
  endfunction

  function automatic logic [31:0] mk_add(input int rd, input int rs1, input int rs2);
    mk_add = {7'd0, 5'(rs2), 5'(rs1), 3'b000, 5'(rd), 7'b0110011};
  endfunction

  // {reads rs1, reads rs2, writes rd, is load}
  function automatic logic [3:0] dec(input logic [31:0] i);
    case (i[6:0])
      7'b0110111, 7'b0010111, 7'b1101111: dec = 4'b0010;
      7'b1100111, 7'b0010011:             dec = 4'b1010;
      7'b0000011:                         dec = 4'b1011;
      7'b1100011, 7'b0100011:             dec = 4'b1100;
      7'b0110011:                         dec = 4'b1110;
      default:                            dec = 4'b0000;
    endcase
  endfunction

  function automatic bit m_busy(input int r, input bit d, input int dr);
    m_busy = (r != 0) && m_pend[r] && !(BYP && d && (dr == r));
  endfunction

  function automatic bit m_hazard(input logic [31:0] i, input bit d, input int dr);
    logic [3:0] f;
    f = dec(i);
    m_hazard = (f[3] && m_busy(int'(i[19:15]), d, dr)) ||
               (f[2] && m_busy(int'(i[24:20]), d, dr)) ||
               (f[1] && m_busy(int'(i[11:7]),  d, dr)) ||
               (f[0] && (m_cnt == MAXL) && !(BYP && d));
  endfunction

  task automatic m_clear();
    m_pend = '0; m_cnt = 0; m_err = 0; m_stalled = 0; m_held = '0;
  endtask

  task automatic m_step(input logic [31:0] i, input bit v, input bit d, input int r, input bit st);
    logic [31:0] c;
    bit ld_issue;
    c = m_stalled ? m_held : i;
    ld_issue = v && !st && dec(c)[0];
    if (d && r != 0 && !m_pend[r]) m_err = 1;
    if (d && !ld_issue && m_cnt == 0) m_err = 1;
    else m_cnt = m_cnt + int'(ld_issue) - int'(d);
    if (d) m_pend[r] = 1'b0;
    if (ld_issue && c[11:7] != 0) m_pend[c[11:7]] = 1'b1;
    if (!m_stalled && st) m_held = i;
    m_stalled = st;
  endtask

  // Drives one cycle, samples stall before the edge, advances the model across the edge.
  task automatic tick(input logic [31:0] i, input logic v, input logic d, input logic [4:0] r,
                      output logic obs, output logic exp);
    logic [31:0] c;
    instr = i; valid = v; done = d; drd = r;
    #2;
    obs = stall;
    c = m_stalled ? m_held : i;
    exp = v && m_hazard(c, d, int'(r));
    m_step(i, v, d, int'(r), exp);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    instr = '0; valid = 0; done = 0; drd = '0;
    rstn = 0;
    m_clear();
    repeat (2) @(posedge clk);
    #1 rstn = 1;
  endtask

  task automatic test_reset();
    logic o, e;
    do_reset();
    vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL rst_stall: got %b want 0", stall); end
    vectors++; if (pend !== 32'h0) begin miscompares++; $display("FAIL rst_pend: got %h want 0", pend); end
    vectors++; if (outst !== 2'd0) begin miscompares++; $display("FAIL rst_outst: got %0d want 0", outst); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL rst_err: got %b want 0", err); end
    tick(mk_add(3, 1, 2), 1, 0, 0, o, e);
    vectors++; if (o !== 1'b0) begin miscompares++; $display("FAIL rst_add_stall: got %b want 0", o); end
  endtask

  task automatic test_load_use();
    logic o, e;
    do_reset();
    tick(mk_load(5, 1), 1, 0, 0, o, e);
    vectors++; if (o !== 1'b0) begin miscompares++; $display("FAIL lu_lw_stall: got %b want 0", o); end
    vectors++; if (pend !== 32'h20) begin miscompares++; $display("FAIL lu_pend: got %h want 20", pend); end
    vectors++; if (outst !== 2'd1) begin miscompares++; $display("FAIL lu_outst: got %0d want 1", outst); end
    repeat (2) begin
      tick(mk_add(6, 5, 2), 1, 0, 0, o, e);
      vectors++; if (o !== 1'b1) begin miscompares++; $display("FAIL lu_add_stall: got %b want 1", o); end
      vectors++; if (pend !== 32'h20) begin miscompares++; $display("FAIL lu_pend_hold: got %h want 20", pend); end
    end
    tick(mk_add(6, 5, 2), 1, 1, 5, o, e);
    vectors++; if (o !== !BYP) begin miscompares++; $display("FAIL lu_done_stall: got %b want %b", o, !BYP); end
    vectors++; if (pend !== 32'h0) begin miscompares++; $display("FAIL lu_pend_clr: got %h want 0", pend); end
    vectors++; if (outst !== 2'd0) begin miscompares++; $display("FAIL lu_outst_clr: got %0d want 0", outst); end
    tick(mk_add(6, 5, 2), 1, 0, 0, o, e);
    vectors++; if (o !== 1'b0) begin miscompares++; $display("FAIL lu_after_stall: got %b want 0", o); end
  endtask

  task automatic test_x0();
    logic o, e;
    do_reset();
    tick(mk_load(0, 1), 1, 0, 0, o, e);
    vectors++; if (o !== 1'b0) begin miscompares++; $display("FAIL x0_lw_stall: got %b want 0", o); end
    vectors++; if (outst !== 2'd1) begin miscompares++; $display("FAIL x0_outst: got %0d want 1", outst); end
    tick(mk_add(3, 0, 0), 1, 0, 0, o, e);
    vectors++; if (o !== 1'b0) begin miscompares++; $display("FAIL x0_add_stall: got %b want 0", o); end
    vectors++; if (pend !== 32'h0) begin miscompares++; $display("FAIL x0_pend: got %h want 0", pend); end
    tick('0, 0, 1, 0, o, e);
    vectors++; if (outst !== 2'd0) begin miscompares++; $display("FAIL x0_outst_done: got %0d want 0", outst); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL x0_err: got %b want 0", err); end
  endtask

  task automatic test_limit();
    logic o, e;
    do_reset();
    tick(mk_load(5, 1), 1, 0, 0, o, e);
    tick(mk_load(6, 1), 1, 0, 0, o, e);
    vectors++; if (outst !== 2'd2) begin miscompares++; $display("FAIL lim_outst2: got %0d want 2", outst); end
    tick(mk_load(7, 1), 1, 0, 0, o, e);
    vectors++; if (o !== 1'b1) begin miscompares++; $display("FAIL lim_third_stall: got %b want 1", o); end
    vectors++; if (outst !== 2'd2) begin miscompares++; $display("FAIL lim_outst_full: got %0d want 2", outst); end
    tick(mk_load(7, 1), 1, 1, 5, o, e);
    vectors++; if (o !== !BYP) begin miscompares++; $display("FAIL lim_done_stall: got %b want %b", o, !BYP); end
    if (!BYP) begin
      tick(mk_load(7, 1), 1, 0, 0, o, e);
      vectors++; if (o !== 1'b0) begin miscompares++; $display("FAIL lim_issue: got %b want 0", o); end
    end
    vectors++; if (outst !== 2'd2) begin miscompares++; $display("FAIL lim_outst_end: got %0d want 2", outst); end
    vectors++; if (pend !== 32'hC0) begin miscompares++; $display("FAIL lim_pend: got %h want c0", pend); end
  endtask

  task automatic test_waw();
    logic o, e;
    do_reset();
    tick(mk_load(5, 1), 1, 0, 0, o, e);
    tick(mk_load(5, 2), 1, 1, 5, o, e);
    vectors++; if (o !== !BYP) begin miscompares++; $display("FAIL waw_stall: got %b want %b", o, !BYP); end
    if (!BYP) begin
      vectors++; if (pend !== 32'h0) begin miscompares++; $display("FAIL waw_pend_clr: got %h want 0", pend); end
      tick(mk_load(5, 2), 1, 0, 0, o, e);
    end
    vectors++; if (pend !== 32'h20) begin miscompares++; $display("FAIL waw_pend: got %h want 20", pend); end
    vectors++; if (outst !== 2'd1) begin miscompares++; $display("FAIL waw_outst: got %0d want 1", outst); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL waw_err: got %b want 0", err); end
  endtask

  task automatic test_spurious();
    logic o, e;
    do_reset();
    tick('0, 0, 1, 9, o, e);
    vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL sp_err: got %b want 1", err); end
    vectors++; if (outst !== 2'd0) begin miscompares++; $display("FAIL sp_outst: got %0d want 0", outst); end
    repeat (3) tick('0, 0, 0, 0, o, e);
    vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL sp_err_sticky: got %b want 1", err); end
  endtask

  task automatic test_reset_in_stall();
    logic o, e;
    do_reset();
    tick(mk_load(5, 1), 1, 0, 0, o, e);
    tick(mk_add(6, 5, 2), 1, 0, 0, o, e);
    vectors++; if (stall !== 1'b1) begin miscompares++; $display("FAIL rs_pre_stall: got %b want 1", stall); end
    #2 rstn = 0;
    m_clear();
    #1;
    vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL rs_stall: got %b want 0", stall); end
    vectors++; if (pend !== 32'h0) begin miscompares++; $display("FAIL rs_pend: got %h want 0", pend); end
    vectors++; if (outst !== 2'd0) begin miscompares++; $display("FAIL rs_outst: got %0d want 0", outst); end
    @(posedge clk); #1 rstn = 1;
    tick(mk_add(6, 5, 2), 1, 0, 0, o, e);
    vectors++; if (o !== 1'b0) begin miscompares++; $display("FAIL rs_add_after: got %b want 0", o); end
    tick('0, 0, 1, 5, o, e);
    vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL rs_late_done_err: got %b want 1", err); end
  endtask

  task automatic test_random();
    logic [6:0]  ops [10] = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
                              7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011, 7'b1110011};
    logic [31:0] i;
    logic        v, d, o, e, last_e;
    logic [4:0]  r;
    int          inflight[$];
    int          k;
    do_reset();
    i = '0; v = 0; last_e = 0;
    for (int n = 0; n < 1500; n++) begin
      if (!last_e) begin
        v = ($urandom_range(0, 3) != 0);
        i = $urandom;
        i[6:0]   = ops[$urandom_range(0, 9)];
        i[11:7]  = 5'($urandom_range(0, 7));
        i[19:15] = 5'($urandom_range(0, 7));
        i[24:20] = 5'($urandom_range(0, 7));
      end
      d = 0; r = '0;
      if (inflight.size() > 0 && $urandom_range(0, 2) == 0) begin
        k = $urandom_range(0, inflight.size() - 1);
        d = 1; r = 5'(inflight[k]);
        inflight.delete(k);
      end
      tick(i, v, d, r, o, e);
      if (v && !e && dec(i)[0]) inflight.push_back(int'(i[11:7]));
      last_e = e;
      vectors++; if (o !== e) begin miscompares++; $display("FAIL rnd_stall[%0d]: got %b want %b", n, o, e); end
      vectors++; if (pend !== m_pend) begin miscompares++; $display("FAIL rnd_pend[%0d]: got %h want %h", n, pend, m_pend); end
      vectors++; if (outst !== 2'(m_cnt)) begin miscompares++; $display("FAIL rnd_outst[%0d]: got %0d want %0d", n, outst, m_cnt); end
      vectors++; if (err !== m_err) begin miscompares++; $display("FAIL rnd_err[%0d]: got %b want %b", n, err, m_err); end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded its time limit");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_load_use();
    test_x0();
    test_limit();
    test_waw();
    test_spurious();
    test_reset_in_stall();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
